rv32v_multiply_unit_pipe: RTL and testbench

//  Pipelined, multi-lane vector integer multiply unit for the RV32V execute stage. Each lane holds one 32-bit

---
 rtl/rv32v_multiply_unit_pipe.sv | 194 +++++++++++++++++++
 tb/tb_rv32v_multiply_unit_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_multiply_unit_pipe.sv
// Pipelined multi-lane vector integer multiply unit (vmul/vmulh*/widening/MACC/MADD).
// Define RV32V_MUL_VSMUL_EN to enable the fixed-point vsmul operation (multiply_type 11).
module rv32v_multiply_unit_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_mu,
  input  logic                  stall_mu,
  input  logic                  flush_mu,
  input  logic [LANES*32-1:0]   vs1_data,
  input  logic [LANES*32-1:0]   vs2_data,
  input  logic [LANES*32-1:0]   vs3_data,
  input  logic [1:0]            sew,
  input  logic [1:0]            is_signed,
  input  logic [1:0]            multiply_type,
  input  logic                  multiply_pos_neg,
  input  logic                  high_low,
  input  logic                  mul_widen_ena,
  output logic [LANES*32-1:0]   wdata_mu,
  output logic                  done_mu,
  output logic                  ready_mu,
  output logic                  busy_mu,
  output logic                  next_busy_mu,
  output logic                  exception_mu,
  output logic                  sat_mu
);

  localparam logic [1:0] MT_MUL   = 2'b00;
  localparam logic [1:0] MT_MADD  = 2'b10;
  localparam logic [1:0] MT_VSMUL = 2'b11;

  function automatic logic [63:0] widthMask(input int w);
    widthMask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] x, input int w, input logic sgn);
    logic [63:0] m;
    m = widthMask(w);
    extend = x & m;
    if (sgn && x[6'(w-1)]) extend = extend | ~m;
  endfunction

  // One 32-bit lane: elements are processed in 64-bit arithmetic, then masked to the
  // destination width so no carry ever leaks into a neighbouring element.
  function automatic logic [31:0] laneOp(
    input logic [31:0] a1, a2, a3,
    input logic [1:0]  sewSel, sgnSel, typ,
    input logic        neg, hl, wid
  );
    int w, dw, n;
    logic s1, s2;
    logic [63:0] src1, srcM, addend, prod, res;
`ifdef RV32V_MUL_VSMUL_EN
    logic [63:0] mnMin;
`endif
    logic [31:0] outv;
    w    = 8 << sewSel;
    dw   = wid ? 2 * w : w;
    n    = 32 / dw;
    s1   = (typ == MT_VSMUL) | sgnSel[1];
    s2   = (typ == MT_VSMUL) | sgnSel[0];
    outv = '0;
    for (int e = 0; e < 4; e++) begin
      if (e < n) begin
        src1   = extend(64'(a1) >> (e * w), w, s1);
        srcM   = extend(64'((typ == MT_MADD) ? a3 : a2) >> (e * w), w, s2);
        addend = 64'((typ == MT_MADD) ? a2 : a3) >> (e * dw);
        prod   = src1 * srcM;
        if (neg) prod = -prod;
        case (typ)
          MT_MUL: res = hl ? (prod >> w) : prod;
`ifdef RV32V_MUL_VSMUL_EN
          MT_VSMUL: begin
            mnMin = widthMask(w) & ~widthMask(w - 1);
            if (((src1 & widthMask(w)) == mnMin) && ((srcM & widthMask(w)) == mnMin))
              res = widthMask(w - 1);
            else
              res = 64'($signed(prod + (64'd1 << (w - 2))) >>> (w - 1));
          end
`endif
          default: res = addend + prod;
        endcase
        outv = outv | 32'((res & widthMask(dw)) << (e * dw));
      end
    end
    laneOp = outv;
  endfunction

`ifdef RV32V_MUL_VSMUL_EN
  function automatic logic laneSat(input logic [31:0] a1, a2, input logic [1:0] sewSel);
    int w;
    logic [63:0] m, mn;
    w = 8 << sewSel;
    m = widthMask(w);
    mn = m & ~widthMask(w - 1);
    laneSat = 1'b0;
    for (int e = 0; e < 4; e++) begin
      if ((e < 32 / w) && (((64'(a1) >> (e * w)) & m) == mn) && (((64'(a2) >> (e * w)) & m) == mn))
        laneSat = 1'b1;
    end
  endfunction
`endif

  logic [LANES*32-1:0] r_vs1, r_vs2, r_vs3;
  logic [1:0]          r_sew, r_sgn, r_typ;
  logic                r_neg, r_hl, r_wid;
  logic [STAGES-1:0]   r_valid;
  logic [LANES*32-1:0] r_data [1:STAGES-1];
  logic [STAGES-1:1]   r_exc;
  logic [STAGES-1:1]   r_sat;
  logic [LANES*32-1:0] w_result;
  logic                w_exc;
  logic                w_sat;
  logic                w_accept;

  assign w_accept = start_mu && !stall_mu;

  // Stage 0 only latches operands; arithmetic happens between stage 0 and stage 1.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_vs1 <= vs1_data;
      r_vs2 <= vs2_data;
      r_vs3 <= vs3_data;
      r_sew <= sew;
      r_sgn <= is_signed;
      r_typ <= multiply_type;
      r_neg <= multiply_pos_neg;
      r_hl  <= high_low;
      r_wid <= mul_widen_ena;
    end
  end

  always_comb begin
    w_exc = (r_sew == 2'b11) || (r_sgn == 2'b10) || (r_wid && (r_sew == 2'b10)) ||
            (r_hl && (r_typ != MT_MUL)) || (r_wid && r_hl);
`ifdef RV32V_MUL_VSMUL_EN
    w_exc = w_exc || ((r_typ == MT_VSMUL) && r_wid);
`else
    w_exc = w_exc || (r_typ == MT_VSMUL);
`endif
  end

  always_comb begin
    w_result = '0;
    w_sat    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_result[l*32 +: 32] = laneOp(r_vs1[l*32 +: 32], r_vs2[l*32 +: 32], r_vs3[l*32 +: 32],
                                    r_sew, r_sgn, r_typ, r_neg, r_hl, r_wid);
`ifdef RV32V_MUL_VSMUL_EN
      if (r_typ == MT_VSMUL)
        w_sat = w_sat | laneSat(r_vs1[l*32 +: 32], r_vs2[l*32 +: 32], r_sew);
`endif
    end
    if (w_exc) begin
      w_result = '0;
      w_sat    = 1'b0;
    end
  end

  // Bubbles carry zero payload, so the output regs read 0 whenever done_mu is low after a gap.
  always_ff @(posedge CLK) begin
    if (RST || flush_mu) begin
      r_valid <= '0;
      r_exc   <= '0;
      r_sat   <= '0;
      for (int s = 1; s < STAGES; s++) r_data[s] <= '0;
    end else if (!stall_mu) begin
      r_valid[0] <= start_mu;
      for (int s = 1; s < STAGES; s++) r_valid[s] <= r_valid[s-1];
      r_data[1] <= r_valid[0] ? w_result : '0;
      r_exc[1]  <= r_valid[0] & w_exc;
      r_sat[1]  <= r_valid[0] & w_sat;
      for (int s = 2; s < STAGES; s++) begin
        r_data[s] <= r_data[s-1];
        r_exc[s]  <= r_exc[s-1];
        r_sat[s]  <= r_sat[s-1];
      end
    end
  end

  assign wdata_mu     = r_data[STAGES-1];
  assign done_mu      = r_valid[STAGES-1];
  assign exception_mu = r_exc[STAGES-1];
  assign sat_mu       = r_sat[STAGES-1];
  assign ready_mu     = !stall_mu;
  assign busy_mu      = |r_valid;

  // While stalled the output stage does not retire, so it still counts towards next-cycle busy.
  assign next_busy_mu = !RST && !flush_mu &&
                        ((stall_mu ? (|r_valid) : (|r_valid[STAGES-2:0])) || w_accept);

endmodule

// File: tb/tb_rv32v_multiply_unit_pipe.sv
// Self-checking bench for rv32v_multiply_unit_pipe: vector table plus stall/flush/reset sequences,
// results checked through an in-order scoreboard.
module tb_rv32v_multiply_unit_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 3;

  typedef struct {
    logic [127:0] vs1, vs2, vs3;
    logic [1:0]   sew, sgn, typ;
    logic         neg, hl, wid;
    logic [127:0] expData;
    logic         expExc, expSat;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic         exc, sat;
  } exp_t;

  logic                CLK, RST, start_mu, stall_mu, flush_mu;
  logic [LANES*32-1:0] vs1_data, vs2_data, vs3_data, wdata_mu;
  logic [1:0]          sew, is_signed, multiply_type;
  logic                multiply_pos_neg, high_low, mul_widen_ena;
  logic                done_mu, ready_mu, busy_mu, next_busy_mu, exception_mu, sat_mu;

  int   checks  = 0;
  int   errors  = 0;
  int   retired = 0;
  exp_t sbQ[$];
  exp_t head;
  vec_t vecs[20];
  vec_t idleVec;

  rv32v_multiply_unit_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .CLK(CLK), .RST(RST), .start_mu(start_mu), .stall_mu(stall_mu), .flush_mu(flush_mu),
    .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data),
    .sew(sew), .is_signed(is_signed), .multiply_type(multiply_type),
    .multiply_pos_neg(multiply_pos_neg), .high_low(high_low), .mul_widen_ena(mul_widen_ena),
    .wdata_mu(wdata_mu), .done_mu(done_mu), .ready_mu(ready_mu), .busy_mu(busy_mu),
    .next_busy_mu(next_busy_mu), .exception_mu(exception_mu), .sat_mu(sat_mu)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mkVec(input logic [31:0] v1, v2, v3, input logic [1:0] s, g, t,
                                 input logic n, h, w, input logic [31:0] expLane,
                                 input logic exc, sat);
    vec_t v;
    v.vs1 = {4{v1}}; v.vs2 = {4{v2}}; v.vs3 = {4{v3}};
    v.sew = s; v.sgn = g; v.typ = t; v.neg = n; v.hl = h; v.wid = w;
    v.expData = {4{expLane}}; v.expExc = exc; v.expSat = sat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the scoreboard learns of every accepted op.
  task automatic applyStimulus(input vec_t v, input logic st, input logic stl, input logic fl);
    exp_t e;
    @(posedge CLK); #1;
    vs1_data = v.vs1; vs2_data = v.vs2; vs3_data = v.vs3;
    sew = v.sew; is_signed = v.sgn; multiply_type = v.typ;
    multiply_pos_neg = v.neg; high_low = v.hl; mul_widen_ena = v.wid;
    start_mu = st; stall_mu = stl; flush_mu = fl;
    if (fl) sbQ.delete();
    else if (st && !stl) begin
      e.data = v.expData; e.exc = v.expExc; e.sat = v.expSat;
      sbQ.push_back(e);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sbQ.size() != 0 && k < 50) begin
      applyStimulus(idleVec, 1'b0, 1'b0, 1'b0);
      k++;
    end
    applyStimulus(idleVec, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_queue_empty", 128'(sbQ.size()), 128'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wdata"}, wdata_mu, 128'd0);
    checkOutput({tag, "_done"}, 128'(done_mu), 128'd0);
    checkOutput({tag, "_busy"}, 128'(busy_mu), 128'd0);
    checkOutput({tag, "_next_busy"}, 128'(next_busy_mu), 128'd0);
    checkOutput({tag, "_exception"}, 128'(exception_mu), 128'd0);
    checkOutput({tag, "_sat"}, 128'(sat_mu), 128'd0);
  endtask

  // A result retires on the next edge unless stalled; a held result is re-checked every stalled cycle.
  always @(negedge CLK) begin
    if (!RST && !flush_mu && done_mu) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done actual=%h expected=no result", wdata_mu);
      end else begin
        head = sbQ[0];
        if (wdata_mu !== head.data || exception_mu !== head.exc || sat_mu !== head.sat) begin
          errors++;
          $display("[TB] FAIL scoreboard actual=%h exc=%b sat=%b expected=%h exc=%b sat=%b",
                   wdata_mu, exception_mu, sat_mu, head.data, head.exc, head.sat);
        end
        if (!stall_mu) begin
          void'(sbQ.pop_front());
          retired++;
        end
      end
    end
  end

  initial begin
    int lat;
    int retiredBefore;

    vecs[0]  = mkVec(32'h02020203, 32'h7F80FF02, 32'h0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 32'hFE00FE06, 0, 0);
    vecs[1]  = mkVec(32'h80000000, 32'h80000000, 32'h0, 2'b10, 2'b11, 2'b00, 0, 1, 0, 32'h40000000, 0, 0);
    vecs[2]  = mkVec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'b10, 2'b01, 2'b00, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    vecs[3]  = mkVec(32'h00000002, 32'h0000FFFF, 32'h1, 2'b01, 2'b00, 2'b01, 0, 0, 1, 32'h0001FFFF, 0, 0);
    vecs[4]  = mkVec(32'h3, 32'h3, 32'h0, 2'b10, 2'b00, 2'b00, 0, 0, 1, 32'h0, 1, 0);
`ifdef RV32V_MUL_VSMUL_EN
    vecs[5]  = mkVec(32'h80808080, 32'h80808080, 32'h0, 2'b00, 2'b11, 2'b11, 0, 0, 0, 32'h7F7F7F7F, 0, 1);
`else
    vecs[5]  = mkVec(32'h80808080, 32'h80808080, 32'h0, 2'b00, 2'b11, 2'b11, 0, 0, 0, 32'h0, 1, 0);
`endif
    vecs[6]  = mkVec(32'h00020003, 32'h1234FFFF, 32'h0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 32'h2468FFFD, 0, 0);
    vecs[7]  = mkVec(32'h01010101, 32'h01020304, 32'h10101010, 2'b00, 2'b00, 2'b01, 1, 0, 0, 32'h0F0E0D0C, 0, 0);
    vecs[8]  = mkVec(32'h00000003, 32'h0000000A, 32'hFFFFFFFE, 2'b10, 2'b11, 2'b10, 0, 0, 0, 32'h00000004, 0, 0);
    vecs[9]  = mkVec(32'h80007FFF, 32'h80007FFF, 32'h0, 2'b01, 2'b11, 2'b00, 0, 1, 0, 32'h40003FFF, 0, 0);
    vecs[10] = mkVec(32'h00007F02, 32'h0000FF80, 32'h0, 2'b00, 2'b11, 2'b00, 0, 0, 1, 32'hFF81FF00, 0, 0);
    vecs[11] = mkVec(32'h1, 32'h1, 32'h0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 32'h0, 1, 0);
    vecs[12] = mkVec(32'h1, 32'h1, 32'h0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 32'h0, 1, 0);
    vecs[13] = mkVec(32'h1, 32'h1, 32'h0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 32'h0, 1, 0);
    vecs[14] = mkVec(32'h1, 32'h1, 32'h0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 32'h0, 1, 0);
    vecs[15] = mkVec(32'h000000FF, 32'h000000FF, 32'h0, 2'b00, 2'b01, 2'b00, 0, 1, 0, 32'h000000FF, 0, 0);
    vecs[16] = mkVec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h01010101, 0, 0);
    vecs[17] = mkVec(32'hFFFF0002, 32'h00030005, 32'h00100001, 2'b01, 2'b11, 2'b01, 0, 0, 0, 32'h000D000B, 0, 0);
    vecs[18] = mkVec(32'h10, 32'h0, 32'h0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 32'h0, 0, 0);
    vecs[18].vs2     = 128'h00000005_00000004_00000003_00000002;
    vecs[18].expData = 128'h00000050_00000040_00000030_00000020;
    vecs[19] = mkVec(32'h00000007, 32'h00000006, 32'h0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 32'h0000002A, 0, 0);
    idleVec  = mkVec(32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 32'h0, 0, 0);

    RST = 1'b1; start_mu = 0; stall_mu = 0; flush_mu = 0;
    vs1_data = '0; vs2_data = '0; vs3_data = '0; sew = 0; is_signed = 0; multiply_type = 0;
    multiply_pos_neg = 0; high_low = 0; mul_widen_ena = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkAllZero("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    // Latency of a lone operation from its issue cycle
    applyStimulus(vecs[0], 1'b1, 1'b0, 1'b0);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(idleVec, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      if (done_mu) begin
        lat = c;
        break;
      end
    end
    checkOutput("latency", 128'(lat), 128'(STAGES));
    drain();

    // Whole table back to back
    for (int i = 0; i < 20; i++) applyStimulus(vecs[i], 1'b1, 1'b0, 1'b0);
    drain();

    // Five ops with a two-cycle stall mid-stream; starts during the stall must be ignored
    retiredBefore = retired;
    applyStimulus(vecs[6], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[7], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[8], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[0], 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    checkOutput("stall_ready", 128'(ready_mu), 128'd0);
    applyStimulus(vecs[1], 1'b1, 1'b1, 1'b0);
    applyStimulus(vecs[9], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[10], 1'b1, 1'b0, 1'b0);
    drain();
    checkOutput("stall_retired_count", 128'(retired - retiredBefore), 128'd5);

    // Flush with the pipe full and a start in the same cycle
    applyStimulus(vecs[16], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[6], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[17], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[1], 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    checkOutput("flush_next_busy", 128'(next_busy_mu), 128'd0);
    applyStimulus(idleVec, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    checkOutput("flush_busy", 128'(busy_mu), 128'd0);
    checkOutput("flush_done", 128'(done_mu), 128'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(idleVec, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      checkOutput("flush_no_done", 128'(done_mu), 128'd0);
    end

    // Reset in the middle of a stream
    applyStimulus(vecs[7], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[5], 1'b1, 1'b0, 1'b0);
    applyStimulus(vecs[8], 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b1; start_mu = 1'b0;
    sbQ.delete();
    @(negedge CLK);
    checkOutput("rst_next_busy", 128'(next_busy_mu), 128'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkAllZero("midrst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
